// File: rtl/sdp_ram_arbiter_pkg.sv
// Shared constants and helpers for the simple dual-port RAM arbiter.
// COMMON_BRAM_DELAY normally comes from the project-wide common_defines.vh.
// The fallback below keeps this slice self-contained when that header is absent.
`ifndef COMMON_BRAM_DELAY
`define COMMON_BRAM_DELAY 2
`endif

package sdp_ram_arbiter_pkg;

  localparam int DEF_COE_WIDTH  = 39;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_N_REQ      = 4;
  localparam int DEF_BRAM_DELAY = `COMMON_BRAM_DELAY;

  // Advance a requester index by one, wrapping at n (n need not be a power of two).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sdp_ram_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from req and a priority pointer.
// The pointer moves to the slot after the winner and holds when nothing is granted.
module rr_arbiter
  import sdp_ram_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  output logic [N_REQ-1:0]           gnt,
  output logic [$clog2(N_REQ)-1:0]   gnt_id,
  output logic                       gnt_any
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0] r_ptr;
  int              w_idx;

  // Pick the first requester at or after the pointer; no grant while in reset.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    w_idx   = 0;
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        w_idx = int'(r_ptr) + i;
        if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
        if (!gnt_any && req[w_idx]) begin
          gnt[w_idx] = 1'b1;
          gnt_id     = ID_W'(w_idx);
          gnt_any    = 1'b1;
        end
      end
    end
  end

  // Priority pointer: restart search after the winner, hold when idle.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_ptr <= '0;
    end else if (gnt_any) begin
      r_ptr <= ID_W'(wrap_inc(int'(gnt_id), N_REQ));
    end
  end

endmodule

// File: rtl/sdp_ram_arbiter.sv
// Shares one simple dual-port RAM between N_REQ requesters.
// Independent round-robin arbitration on the write and read ports; a tag pipe
// matched to the RAM read latency steers read data back to the issuing requester.
module sdp_ram_arbiter
  import sdp_ram_arbiter_pkg::*;
#(
  parameter int COE_WIDTH         = DEF_COE_WIDTH,
  parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
  parameter int N_REQ             = DEF_N_REQ,
  parameter int COMMON_BRAM_DELAY = DEF_BRAM_DELAY
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            wr_valid,
  output logic [N_REQ-1:0]            wr_ready,
  input  logic [N_REQ*ADDR_WIDTH-1:0] wr_addr,
  input  logic [N_REQ*COE_WIDTH-1:0]  wr_data,
  input  logic [N_REQ-1:0]            rd_valid,
  output logic [N_REQ-1:0]            rd_ready,
  input  logic [N_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [COE_WIDTH-1:0]        rsp_data,
  output logic                        ram_wea,
  output logic [ADDR_WIDTH-1:0]       ram_addra,
  output logic [COE_WIDTH-1:0]        ram_dina,
  output logic [ADDR_WIDTH-1:0]       ram_addrb,
  input  logic [COE_WIDTH-1:0]        ram_doutb,
  output logic                        idle
);

  localparam int REQ_ID_WIDTH = $clog2(N_REQ);
  localparam int TAG_DEPTH    = 1 + COMMON_BRAM_DELAY;

  // Arbiter outputs
  logic [N_REQ-1:0]        w_wr_gnt;
  logic [REQ_ID_WIDTH-1:0] w_wr_id;
  logic                    w_wr_any;
  logic [N_REQ-1:0]        w_rd_gnt;
  logic [REQ_ID_WIDTH-1:0] w_rd_id;
  logic                    w_rd_any;

  // Winner's payload selected by grant index
  logic [ADDR_WIDTH-1:0]   w_wr_addr;
  logic [COE_WIDTH-1:0]    w_wr_data;
  logic [ADDR_WIDTH-1:0]   w_rd_addr;

  // RAM-side registers
  logic                    r_ram_wea;
  logic [ADDR_WIDTH-1:0]   r_ram_addra;
  logic [COE_WIDTH-1:0]    r_ram_dina;
  logic [ADDR_WIDTH-1:0]   r_ram_addrb;

  // Tag pipe: stage k describes the read whose address reached the RAM k cycles ago
  logic [TAG_DEPTH-1:0]    r_tag_vld;
  logic [REQ_ID_WIDTH-1:0] r_tag_id [TAG_DEPTH];

  logic                    w_rsp_fire;
  logic [COE_WIDTH-1:0]    r_rsp_data;

  rr_arbiter #(.N_REQ(N_REQ)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_valid),
    .gnt     (w_wr_gnt),
    .gnt_id  (w_wr_id),
    .gnt_any (w_wr_any)
  );

  rr_arbiter #(.N_REQ(N_REQ)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_valid),
    .gnt     (w_rd_gnt),
    .gnt_id  (w_rd_id),
    .gnt_any (w_rd_any)
  );

  assign wr_ready  = w_wr_gnt;
  assign rd_ready  = w_rd_gnt;
  assign w_wr_addr = wr_addr[w_wr_id*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wr_data = wr_data[w_wr_id*COE_WIDTH +: COE_WIDTH];
  assign w_rd_addr = rd_addr[w_rd_id*ADDR_WIDTH +: ADDR_WIDTH];

  // Write port: strobe for exactly the cycle after a grant, address/data hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_wea   <= 1'b0;
      r_ram_addra <= '0;
      r_ram_dina  <= '0;
    end else begin
      r_ram_wea <= w_wr_any;
      if (w_wr_any) begin
        r_ram_addra <= w_wr_addr;
        r_ram_dina  <= w_wr_data;
      end
    end
  end

  // Read port: address follows the last grant; the RAM keeps reading in between.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ram_addrb <= '0;
    end else if (w_rd_any) begin
      r_ram_addrb <= w_rd_addr;
    end
  end

  // Tag valids: shift one stage per cycle; reset flushes every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_vld <= '0;
    end else begin
      r_tag_vld <= {r_tag_vld[TAG_DEPTH-2:0], w_rd_any};
    end
  end

  // Tag ids: plain shift register alongside the valids.
  always_ff @(posedge clk) begin
    // NOTE: the id stages are not reset; they are only ever looked at when their valid bit is set.
    r_tag_id[0] <= w_rd_id;
    for (int k = 1; k < TAG_DEPTH; k++) begin
      r_tag_id[k] <= r_tag_id[k-1];
    end
  end

  // Last tag stage lines up with ram_doutb; suppressed while reset is asserted.
  assign w_rsp_fire = r_tag_vld[TAG_DEPTH-1] & ~rst;

  // Response data holder: keeps the last delivered word between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_data <= '0;
    end else if (w_rsp_fire) begin
      r_rsp_data <= ram_doutb;
    end
  end

  assign rsp_valid = w_rsp_fire ? (N_REQ'(1) << r_tag_id[TAG_DEPTH-1]) : '0;
  assign rsp_data  = w_rsp_fire ? ram_doutb : r_rsp_data;

  assign ram_wea   = r_ram_wea;
  assign ram_addra = r_ram_addra;
  assign ram_dina  = r_ram_dina;
  assign ram_addrb = r_ram_addrb;
  assign idle      = ~(|r_tag_vld) & ~r_ram_wea;

endmodule

// File: tb/tb_sdp_ram_arbiter.sv
// Directed bench for sdp_ram_arbiter with a read-first, fixed-latency RAM model.
module tb_sdp_ram_arbiter;

  localparam int CW = 39;
  localparam int AW = 9;
  localparam int N  = 4;
  localparam int D  = sdp_ram_arbiter_pkg::DEF_BRAM_DELAY;

  localparam logic [CW-1:0] T3_DATA [4] = '{39'h01_0000_0A01, 39'h02_0000_0B02,
                                            39'h03_0000_0C03, 39'h04_0000_0D04};

  logic              clk;
  logic              rst;
  logic [N-1:0]      wr_valid;
  logic [N-1:0]      wr_ready;
  logic [N*AW-1:0]   wr_addr;
  logic [N*CW-1:0]   wr_data;
  logic [N-1:0]      rd_valid;
  logic [N-1:0]      rd_ready;
  logic [N*AW-1:0]   rd_addr;
  logic [N-1:0]      rsp_valid;
  logic [CW-1:0]     rsp_data;
  logic              ram_wea;
  logic [AW-1:0]     ram_addra;
  logic [CW-1:0]     ram_dina;
  logic [AW-1:0]     ram_addrb;
  logic [CW-1:0]     ram_doutb;
  logic              idle;

  int n_checks = 0;
  int n_pass   = 0;

  sdp_ram_arbiter #(
    .COE_WIDTH(CW), .ADDR_WIDTH(AW), .N_REQ(N), .COMMON_BRAM_DELAY(D)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first RAM with D cycles of read latency.
  logic [CW-1:0] mem     [1 << AW];
  logic [CW-1:0] rd_pipe [D];

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    rd_pipe[0] <= mem[ram_addrb];
    for (int i = 1; i < D; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign ram_doutb = rd_pipe[D-1];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Every stimulus block starts and ends one time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_valids();
    wr_valid = '0;
    rd_valid = '0;
  endtask

  task automatic drive_wr(input int id, input logic [AW-1:0] a, input logic [CW-1:0] d);
    wr_valid             = N'(1) << id;
    wr_addr[id*AW +: AW] = a;
    wr_data[id*CW +: CW] = d;
  endtask

  task automatic drive_rd(input int id, input logic [AW-1:0] a);
    rd_valid             = N'(1) << id;
    rd_addr[id*AW +: AW] = a;
  endtask

  // Single read by one requester, checking grant, address and the tagged response.
  task automatic rd_expect(input string tag, input int id, input logic [AW-1:0] a,
                           input logic [CW-1:0] d);
    drive_rd(id, a);
    #1;
    check({tag, "_rd_ready"}, 64'(rd_ready), 64'(N'(1) << id));
    for (int k = 1; k <= D + 1; k++) begin
      step();
      clear_valids();
      #1;
      if (k == 1) check({tag, "_addrb"}, 64'(ram_addrb), 64'(a));
      if (k <= D) begin
        check({tag, "_rsp_early"}, 64'(rsp_valid), 64'(0));
      end else begin
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(N'(1) << id));
        check({tag, "_rsp_data"}, 64'(rsp_data), 64'(d));
      end
    end
    step();
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = '0;
    rd_valid = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr  = '0;
    step();

    // 1. Reset then idle; last reset cycle also raises every valid.
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        wr_valid = '1;
        rd_valid = '1;
      end
      #1;
      check("t1_wr_ready", 64'(wr_ready), 64'(0));
      check("t1_rd_ready", 64'(rd_ready), 64'(0));
      check("t1_wea", 64'(ram_wea), 64'(0));
      check("t1_rsp_valid", 64'(rsp_valid), 64'(0));
      check("t1_idle", 64'(idle), 64'(1));
      if (c == 1) begin
        check("t1_addra", 64'(ram_addra), 64'(0));
        check("t1_dina", 64'(ram_dina), 64'(0));
        check("t1_addrb", 64'(ram_addrb), 64'(0));
        check("t1_rsp_data", 64'(rsp_data), 64'(0));
      end
      step();
    end
    clear_valids();
    rst = 1'b0;

    // 2. Single write then read by requester 1.
    drive_wr(1, 9'h05, 39'h12_3456_789A);
    #1;
    check("t2_wr_ready", 64'(wr_ready), 64'b0010);
    step();
    clear_valids();
    #1;
    check("t2_wea", 64'(ram_wea), 64'(1));
    check("t2_addra", 64'(ram_addra), 64'h05);
    check("t2_dina", 64'(ram_dina), 64'h12_3456_789A);
    check("t2_busy", 64'(idle), 64'(0));
    step();
    #1;
    check("t2_wea_drop", 64'(ram_wea), 64'(0));
    check("t2_idle", 64'(idle), 64'(1));
    step();
    rd_expect("t2", 1, 9'h05, 39'h12_3456_789A);

    // 3. Fairness: fresh reset, preload 0x30..0x33, then all four read together.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_wr(i, AW'(9'h30 + i), T3_DATA[i]);
      step();
    end
    clear_valids();
    step();
    for (int i = 0; i < 4; i++) rd_addr[i*AW +: AW] = AW'(9'h30 + i);
    for (int c = 0; c <= 8 + D; c++) begin
      rd_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) check("t3_rd_ready", 64'(rd_ready), 64'(N'(1) << (c % 4)));
      if (c >= 1 + D) begin
        check("t3_rsp_valid", 64'(rsp_valid), 64'(N'(1) << ((c - 1 - D) % 4)));
        check("t3_rsp_data", 64'(rsp_data), 64'(T3_DATA[(c - 1 - D) % 4]));
      end else begin
        check("t3_rsp_quiet", 64'(rsp_valid), 64'(0));
      end
      step();
    end

    // 4. Concurrent ports: req0 writes 0x10 while req2 reads 0x20 (preloaded).
    drive_wr(3, 9'h20, 39'h55_AAAA_5555);
    step();
    clear_valids();
    step();
    drive_wr(0, 9'h10, 39'h7F_0000_0010);
    drive_rd(2, 9'h20);
    #1;
    check("t4_wr_ready", 64'(wr_ready), 64'b0001);
    check("t4_rd_ready", 64'(rd_ready), 64'b0100);
    for (int k = 1; k <= D + 1; k++) begin
      step();
      clear_valids();
      #1;
      if (k == 1) begin
        check("t4_wea", 64'(ram_wea), 64'(1));
        check("t4_addra", 64'(ram_addra), 64'h10);
        check("t4_addrb", 64'(ram_addrb), 64'h20);
      end
      if (k == D + 1) begin
        check("t4_rsp_valid", 64'(rsp_valid), 64'b0100);
        check("t4_rsp_data", 64'(rsp_data), 64'h55_AAAA_5555);
      end
    end
    step();
    rd_expect("t4_back", 0, 9'h10, 39'h7F_0000_0010);

    // 5. Read-first collision on 0x07, then a read one cycle later.
    drive_wr(1, 9'h07, 39'h00_DEAD_BEEF);
    step();
    clear_valids();
    step();
    drive_wr(1, 9'h07, 39'h4C_0FFE_E000);
    drive_rd(3, 9'h07);
    #1;
    check("t5_wr_ready", 64'(wr_ready), 64'b0010);
    check("t5_rd_ready0", 64'(rd_ready), 64'b1000);
    step();
    wr_valid = '0;
    drive_rd(3, 9'h07);
    #1;
    check("t5_rd_ready1", 64'(rd_ready), 64'b1000);
    check("t5_collide", 64'({ram_wea, ram_addra == ram_addrb}), 64'b11);
    step();
    clear_valids();
    for (int j = 0; j <= D; j++) begin
      #1;
      if (j == D - 1) begin
        check("t5_old_valid", 64'(rsp_valid), 64'b1000);
        check("t5_old_data", 64'(rsp_data), 64'h00_DEAD_BEEF);
      end
      if (j == D) begin
        check("t5_new_valid", 64'(rsp_valid), 64'b1000);
        check("t5_new_data", 64'(rsp_data), 64'h4C_0FFE_E000);
      end
      step();
    end

    // 6. Reset flush: three reads by req0, reset one cycle after the last grant.
    for (int z = 0; z < 3; z++) begin
      drive_rd(0, 9'h05);
      #1;
      check("t6_rd_ready", 64'(rd_ready), 64'b0001);
      step();
    end
    clear_valids();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("t6_rst_rsp", 64'(rsp_valid), 64'(0));
      step();
    end
    rst = 1'b0;
    for (int c = 0; c < D + 2; c++) begin
      #1;
      check("t6_flush_rsp", 64'(rsp_valid), 64'(0));
      check("t6_idle", 64'(idle), 64'(1));
      step();
    end
    wr_valid = '1;
    rd_valid = '1;
    #1;
    check("t6_rd_ptr", 64'(rd_ready), 64'b0001);
    check("t6_wr_ptr", 64'(wr_ready), 64'b0001);
    step();
    clear_valids();
    for (int c = 0; c < D + 3; c++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
